// File: rtl/mem_port_arbiter.sv
// Single-port data memory arbiter: committed stores vs. speculative loads, one
// transaction in flight, byte/half/word formatting and tagged load returns.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int TAG_W      = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [1:0]        ld_req_size,
    input  logic              ld_req_signed,
    input  logic [TAG_W-1:0]  ld_req_tag,
    input  logic              st_req_valid,
    output logic              st_req_ready,
    input  logic [ADDR_W-1:0] st_req_addr,
    input  logic [1:0]        st_req_size,
    input  logic [31:0]       st_req_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              ld_resp_valid,
    output logic [TAG_W-1:0]  ld_resp_tag,
    output logic [31:0]       ld_resp_data,
    output logic              st_done
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_t            state_q, state_d;
    logic              is_ld_q, is_ld_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              squash_q, squash_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              ld_resp_valid_q, ld_resp_valid_d;
    logic [TAG_W-1:0]  ld_resp_tag_q, ld_resp_tag_d;
    logic [31:0]       ld_resp_data_q, ld_resp_data_d;
    logic              st_done_q, st_done_d;

    logic        grant_st, grant_ld;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_data;

    // A flushed cycle cannot take a load, so a waiting store goes instead.
    always_comb begin
        grant_st = 1'b0;
        grant_ld = 1'b0;
        if (state_q == IDLE) begin
            if (st_req_valid && (!ld_req_valid || flush || starve_cnt_q < STARVE_LIM))
                grant_st = 1'b1;
            else if (ld_req_valid && !flush)
                grant_ld = 1'b1;
        end
    end

    assign st_req_ready = grant_st;
    assign ld_req_ready = grant_ld;

    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = st_req_data;
        case (st_req_size)
            2'd0: begin
                st_wstrb = 4'b0001 << st_req_addr[1:0];
                st_wdata = {4{st_req_data[7:0]}};
            end
            2'd1: begin
                st_wstrb = st_req_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_req_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_lo_q)
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'd0:    ld_data = {{24{signed_q & lane_b[7]}}, lane_b};
            2'd1:    ld_data = {{16{signed_q & lane_h[15]}}, lane_h};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        is_ld_d         = is_ld_q;
        addr_lo_d       = addr_lo_q;
        size_d          = size_q;
        signed_d        = signed_q;
        tag_d           = tag_q;
        squash_d        = squash_q;
        starve_cnt_d    = starve_cnt_q;
        mem_valid_d     = mem_valid_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wstrb_d     = mem_wstrb_q;
        mem_wdata_d     = mem_wdata_q;
        ld_resp_valid_d = 1'b0;
        ld_resp_tag_d   = ld_resp_tag_q;
        ld_resp_data_d  = ld_resp_data_q;
        st_done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_ld) begin
                    state_d      = REQ;
                    is_ld_d      = 1'b1;
                    addr_lo_d    = ld_req_addr[1:0];
                    size_d       = ld_req_size;
                    signed_d     = ld_req_signed;
                    tag_d        = ld_req_tag;
                    squash_d     = 1'b0;
                    starve_cnt_d = '0;
                    mem_valid_d  = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = {ld_req_addr[ADDR_W-1:2], 2'b00};
                    mem_wstrb_d  = 4'b0000;
                    mem_wdata_d  = '0;
                end else if (grant_st) begin
                    state_d     = REQ;
                    is_ld_d     = 1'b0;
                    squash_d    = 1'b0;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {st_req_addr[ADDR_W-1:2], 2'b00};
                    mem_wstrb_d = st_wstrb;
                    mem_wdata_d = st_wdata;
                    if (ld_req_valid && starve_cnt_q < STARVE_LIM)
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    else if (!ld_req_valid)
                        starve_cnt_d = '0;
                end else if (!ld_req_valid) begin
                    starve_cnt_d = '0;
                end
            end
            REQ: begin
                if (flush && is_ld_q) squash_d = 1'b1;
                if (mem_ready) begin
                    state_d     = RESP;
                    mem_valid_d = 1'b0;
                end
            end
            RESP: begin
                if (flush && is_ld_q) squash_d = 1'b1;
                if (mem_rvalid) begin
                    state_d = IDLE;
                    if (is_ld_q) begin
                        // A flush landing with the data still kills the result.
                        if (!squash_q && !flush) begin
                            ld_resp_valid_d = 1'b1;
                            ld_resp_tag_d   = tag_q;
                            ld_resp_data_d  = ld_data;
                        end
                    end else begin
                        st_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            is_ld_q         <= 1'b0;
            addr_lo_q       <= '0;
            size_q          <= '0;
            signed_q        <= 1'b0;
            tag_q           <= '0;
            squash_q        <= 1'b0;
            starve_cnt_q    <= '0;
            mem_valid_q     <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wstrb_q     <= '0;
            mem_wdata_q     <= '0;
            ld_resp_valid_q <= 1'b0;
            ld_resp_tag_q   <= '0;
            ld_resp_data_q  <= '0;
            st_done_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            is_ld_q         <= is_ld_d;
            addr_lo_q       <= addr_lo_d;
            size_q          <= size_d;
            signed_q        <= signed_d;
            tag_q           <= tag_d;
            squash_q        <= squash_d;
            starve_cnt_q    <= starve_cnt_d;
            mem_valid_q     <= mem_valid_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wstrb_q     <= mem_wstrb_d;
            mem_wdata_q     <= mem_wdata_d;
            ld_resp_valid_q <= ld_resp_valid_d;
            ld_resp_tag_q   <= ld_resp_tag_d;
            ld_resp_data_q  <= ld_resp_data_d;
            st_done_q       <= st_done_d;
        end
    end

    assign mem_valid     = mem_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wstrb     = mem_wstrb_q;
    assign mem_wdata     = mem_wdata_q;
    assign ld_resp_valid = ld_resp_valid_q;
    assign ld_resp_tag   = ld_resp_tag_q;
    assign ld_resp_data  = ld_resp_data_q;
    assign st_done       = st_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are sampled
// on the falling edge, away from the active rising edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        ld_req_valid, ld_req_ready;
    logic [31:0] ld_req_addr;
    logic [1:0]  ld_req_size;
    logic        ld_req_signed;
    logic [5:0]  ld_req_tag;
    logic        st_req_valid, st_req_ready;
    logic [31:0] st_req_addr;
    logic [1:0]  st_req_size;
    logic [31:0] st_req_data;
    logic        mem_valid, mem_ready, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ld_resp_valid;
    logic [5:0]  ld_resp_tag;
    logic [31:0] ld_resp_data;
    logic        st_done;

    int n_chk = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(32), .TAG_W(6), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
        .ld_req_addr(ld_req_addr), .ld_req_size(ld_req_size),
        .ld_req_signed(ld_req_signed), .ld_req_tag(ld_req_tag),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
        .st_req_addr(st_req_addr), .st_req_size(st_req_size),
        .st_req_data(st_req_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ld_resp_valid(ld_resp_valid), .ld_resp_tag(ld_resp_tag),
        .ld_resp_data(ld_resp_data), .st_done(st_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    string grants;
    string exp_grants;

    initial begin
        rst = 1'b1; flush = 1'b0;
        ld_req_valid = 1'b0; ld_req_addr = '0; ld_req_size = '0;
        ld_req_signed = 1'b0; ld_req_tag = '0;
        st_req_valid = 1'b0; st_req_addr = '0; st_req_size = '0; st_req_data = '0;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_resp", {ld_resp_data[23:0], 2'b0, ld_resp_tag}, 32'd0);
        chk("rst_ld_resp_valid", 32'(ld_resp_valid), 32'd0);
        chk("rst_st_done", 32'(st_done), 32'd0);

        // Signed byte load, minimum latency
        ld_req_valid = 1'b1; ld_req_addr = 32'h1003; ld_req_size = 2'd0;
        ld_req_signed = 1'b1; ld_req_tag = 6'h15;
        settle();
        chk("ld_ready", 32'(ld_req_ready), 32'd1);
        tick();
        ld_req_valid = 1'b0;
        chk("ld_mem_valid", 32'(mem_valid), 32'd1);
        chk("ld_mem_addr", mem_addr, 32'h1000);
        chk("ld_mem_we_wstrb", {27'd0, mem_we, mem_wstrb}, 32'd0);
        tick();
        chk("ld_mem_valid_drop", 32'(mem_valid), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_FF12;
        tick();
        mem_rvalid = 1'b0;
        chk("ld_resp_valid", 32'(ld_resp_valid), 32'd1);
        chk("ld_resp_data", ld_resp_data, 32'hFFFF_FF80);
        chk("ld_resp_tag", 32'(ld_resp_tag), 32'h15);
        tick();
        chk("ld_resp_pulse", 32'(ld_resp_valid), 32'd0);
        chk("ld_resp_data_hold", ld_resp_data, 32'hFFFF_FF80);

        // Half store, upper half
        st_req_valid = 1'b1; st_req_addr = 32'h2002; st_req_size = 2'd1;
        st_req_data = 32'h0000_1234;
        settle();
        chk("st_ready", 32'(st_req_ready), 32'd1);
        tick();
        st_req_valid = 1'b0;
        chk("st_mem_we", 32'(mem_we), 32'd1);
        chk("st_mem_addr", mem_addr, 32'h2000);
        chk("st_mem_wstrb", 32'(mem_wstrb), 32'hC);
        chk("st_mem_wdata", mem_wdata, 32'h1234_1234);
        tick();
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("st_done", 32'(st_done), 32'd1);
        chk("st_no_ld_resp", 32'(ld_resp_valid), 32'd0);
        tick();
        chk("st_done_pulse", 32'(st_done), 32'd0);

        // Backpressure with a byte store
        st_req_valid = 1'b1; st_req_addr = 32'h3001; st_req_size = 2'd0;
        st_req_data = 32'h0000_00AB;
        mem_ready = 1'b0;
        tick();
        st_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(mem_valid), 32'd1);
            chk("bp_addr", mem_addr, 32'h3000);
            chk("bp_wstrb", 32'(mem_wstrb), 32'h2);
            chk("bp_wdata", mem_wdata, 32'hABAB_ABAB);
            if (i < 2) tick();
        end
        mem_ready = 1'b1;
        tick();
        chk("bp_advance", 32'(mem_valid), 32'd0);
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("bp_st_done", 32'(st_done), 32'd1);

        // Flush during load RESP, then pending store proceeds
        ld_req_valid = 1'b1; ld_req_addr = 32'h4000; ld_req_size = 2'd2;
        ld_req_signed = 1'b0; ld_req_tag = 6'h07;
        tick();
        ld_req_valid = 1'b0;
        st_req_valid = 1'b1; st_req_addr = 32'h5000; st_req_size = 2'd2;
        st_req_data = 32'hDEAD_BEEF;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        chk("fl_no_resp", 32'(ld_resp_valid), 32'd0);
        settle();
        chk("fl_st_granted", 32'(st_req_ready), 32'd1);
        tick();
        st_req_valid = 1'b0;
        chk("fl_st_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("fl_st_wstrb", 32'(mem_wstrb), 32'hF);
        tick();
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("fl_st_done", 32'(st_done), 32'd1);

        // Flush in IDLE blocks a lone load; unsigned half load afterwards
        ld_req_valid = 1'b1; ld_req_addr = 32'h6002; ld_req_size = 2'd1;
        ld_req_signed = 1'b0; ld_req_tag = 6'h3C;
        flush = 1'b1;
        settle();
        chk("fl_idle_ready", 32'(ld_req_ready), 32'd0);
        tick();
        chk("fl_idle_no_req", 32'(mem_valid), 32'd0);
        flush = 1'b0;
        settle();
        chk("uh_ready", 32'(ld_req_ready), 32'd1);
        tick();
        ld_req_valid = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h8765_4321;
        tick();
        mem_rvalid = 1'b0;
        chk("uh_valid", 32'(ld_resp_valid), 32'd1);
        chk("uh_data", ld_resp_data, 32'h0000_8765);
        chk("uh_tag", 32'(ld_resp_tag), 32'h3C);

        // Starvation: both requesters held valid, memory answers immediately
        ld_req_valid = 1'b1; ld_req_addr = 32'h0; ld_req_size = 2'd2; ld_req_tag = 6'h01;
        st_req_valid = 1'b1; st_req_addr = 32'h0; st_req_size = 2'd2;
        mem_ready = 1'b1; mem_rvalid = 1'b1;
        grants = "";
        exp_grants = "SSSSLSSSSL";
        for (int c = 0; c < 60 && grants.len() < 10; c++) begin
            settle();
            if (st_req_ready && ld_req_ready) grants = {grants, "X"};
            else if (st_req_ready) grants = {grants, "S"};
            else if (ld_req_ready) grants = {grants, "L"};
            tick();
        end
        n_chk++;
        if (grants != exp_grants) begin
            n_err++;
            $display("FAIL starve_order: got %s expected %s", grants, exp_grants);
        end
        ld_req_valid = 1'b0; st_req_valid = 1'b0;
        repeat (4) tick();
        mem_rvalid = 1'b0;
        tick();

        // Reset mid-REQ abandons the load
        ld_req_valid = 1'b1; ld_req_addr = 32'h7000; ld_req_size = 2'd2; ld_req_tag = 6'h2A;
        mem_ready = 1'b0;
        tick();
        ld_req_valid = 1'b0;
        chk("rq_in_req", 32'(mem_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rq_mem_valid", 32'(mem_valid), 32'd0);
        chk("rq_mem_addr", mem_addr, 32'd0);
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        tick();
        chk("rq_no_resp", 32'(ld_resp_valid), 32'd0);
        chk("rq_no_st_done", 32'(st_done), 32'd0);
        chk("rq_resp_tag", 32'(ld_resp_tag), 32'd0);
        chk("rq_resp_data", ld_resp_data, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
